// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   ifetch_state_e : fetch FSM states
//   INST_W         : instruction word width
//   PC_STEP        : byte distance between consecutive fetch addresses
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD,
    FAULT
  } ifetch_state_e;

  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction bus between the fetch initiator (master) and the address
// decoder / ROM / RAM responders (slave).
//   iadr_o : fetch address, word aligned          (master -> slave)
//   istb_o : strobe, one outstanding transfer      (master -> slave)
//   iack_i : acknowledge, may be combinational     (slave -> master)
//   idat_i : read data, valid on istb_o & iack_i   (slave -> master)
interface instruction_fetch_if
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = 64
) ();

  logic [ADDR_W-1:0] iadr_o;
  logic              istb_o;
  logic              iack_i;
  logic [INST_W-1:0] idat_i;

  modport master (output iadr_o, output istb_o, input iack_i, input idat_i);
  modport slave  (input iadr_o, input istb_o, output iack_i, output idat_i);

endinterface

// File: rtl/instruction_fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of {instruction, pc} pairs between the bus
// side of the fetch unit and decode. Flush has priority over push/pop.
//   clk_i, reset_i : clock, synchronous active-low reset
//   push_i, data_i, pc_i : write one entry (never issued when full)
//   pop_i          : drop the head entry
//   flush_i        : empty the FIFO
//   valid_o, data_o, pc_o : head entry
//   count_o        : occupied entries
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter  int ADDR_W = 64,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              push_i,
  input  logic [INST_W-1:0] data_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic [INST_W-1:0] data_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [INST_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [PTR_W-1:0]  rd_q, wr_q;
  logic [CNT_W-1:0]  count_q;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        data_q[wr_q] <= data_i;
        pc_q[wr_q]   <= pc_i;
        wr_q         <= wr_q + PTR_W'(1);
      end
      if (pop_i) rd_q <= rd_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  assign valid_o = (count_q != '0);
  assign data_o  = data_q[rd_q];
  assign pc_o    = pc_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction-bus initiator: owns the fetch PC, runs one bus transfer at a
// time, queues acknowledged words with their PCs in fetch_fifo for decode,
// and restarts fetch on redirect (dropping any transfer already on the bus).
// Optional macro IFETCH_TIMEOUT_EN adds a bus-timeout fault (FAULT state).
//   clk_i, reset_i            : clock, synchronous active-low reset
//   bus (master)              : iadr_o / istb_o / iack_i / idat_i
//   redirect_i, redirect_pc_i : restart fetch at a new PC
//   inst_valid_o, inst_o, inst_pc_o, inst_ready_i : decode handshake
//   fetch_fault_o             : sticky bus-timeout fault
//
// state   | meaning
// IDLE    | no strobe; waiting for FIFO space
// FETCH   | strobe up, result goes to the FIFO
// DISCARD | strobe up, result dropped, then fetch from tgt_q
// FAULT   | no strobe; timed out, waits for redirect
module instruction_fetch
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'hFFFF_FFFF_FFFF_FF00,
  parameter int                DEPTH    = 2,
  parameter int                TIMEOUT  = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  instruction_fetch_if.master bus,
  input  logic                redirect_i,
  input  logic [ADDR_W-1:0]   redirect_pc_i,
  output logic                inst_valid_o,
  output logic [INST_W-1:0]   inst_o,
  output logic [ADDR_W-1:0]   inst_pc_o,
  input  logic                inst_ready_i,
  output logic                fetch_fault_o
);

  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  ifetch_state_e     state_q;
  logic              istb_q;
  logic [ADDR_W-1:0] adr_q, tgt_q;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_after_pop, count_after;
  logic              ack, pop, push, space_after_pop, space_after_push;
  logic [ADDR_W-1:0] redir_pc;
  logic              unused_redirect_lsb;

  assign ack  = istb_q & bus.iack_i;
  // Redirect flushes the FIFO, so it cancels any push or pop in that cycle.
  assign pop  = inst_valid_o & inst_ready_i & ~redirect_i;
  assign push = (state_q == FETCH) & ack & ~redirect_i;

  assign count_after_pop  = count - CNT_W'(pop);
  assign count_after      = count_after_pop + CNT_W'(push);
  assign space_after_pop  = (count_after_pop < DEPTH_C);
  assign space_after_push = (count_after < DEPTH_C);

  assign redir_pc            = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

`ifdef IFETCH_TIMEOUT_EN
  localparam int              TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q;
  logic             fault_q;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      istb_q  <= 1'b0;
      adr_q   <= RESET_PC;
      tgt_q   <= RESET_PC;
`ifdef IFETCH_TIMEOUT_EN
      tmo_q   <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
`ifdef IFETCH_TIMEOUT_EN
      // Counter restarts unless a branch below keeps it counting.
      tmo_q <= '0;
      if (redirect_i) fault_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (redirect_i) begin
            state_q <= FETCH;
            istb_q  <= 1'b1;
            adr_q   <= redir_pc;
          end else if (space_after_pop) begin
            state_q <= FETCH;
            istb_q  <= 1'b1;
          end
        end
        FETCH: begin
          if (redirect_i) begin
            if (ack) begin
              adr_q <= redir_pc;
            end else begin
              // Address must stay on the bus until the responder acks.
              state_q <= DISCARD;
              tgt_q   <= redir_pc;
            end
          end else if (ack) begin
            adr_q <= adr_q + ADDR_W'(PC_STEP);
            if (!space_after_push) begin
              state_q <= IDLE;
              istb_q  <= 1'b0;
            end
          end
`ifdef IFETCH_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_q <= FAULT;
            istb_q  <= 1'b0;
            fault_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end
        DISCARD: begin
          if (ack) begin
            state_q <= FETCH;
            adr_q   <= redirect_i ? redir_pc : tgt_q;
          end else if (redirect_i) begin
            tgt_q <= redir_pc;
`ifdef IFETCH_TIMEOUT_EN
            // Keep counting but let the redirect win this cycle.
            tmo_q <= (tmo_q == TMO_LAST) ? tmo_q : tmo_q + TMO_W'(1);
`endif
          end
`ifdef IFETCH_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_q <= FAULT;
            istb_q  <= 1'b0;
            fault_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end
`ifdef IFETCH_TIMEOUT_EN
        FAULT: begin
          if (redirect_i) begin
            state_q <= FETCH;
            istb_q  <= 1'b1;
            adr_q   <= redir_pc;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          istb_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.istb_o = istb_q;
  assign bus.iadr_o = adr_q;

`ifdef IFETCH_TIMEOUT_EN
  assign fetch_fault_o = fault_q;
`else
  assign fetch_fault_o = 1'b0;
`endif

  fetch_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .data_i  (bus.idat_i),
    .pc_i    (adr_q),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .valid_o (inst_valid_o),
    .data_o  (inst_o),
    .pc_o    (inst_pc_o),
    .count_o (count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam int          AW  = 64;
  localparam logic [63:0] RPC = 64'hFFFF_FFFF_FFFF_FF00;
  localparam int          DEP = 2;
  localparam int          TMO = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i, redirect_i, inst_ready_i, inst_valid_o, fetch_fault_o;
  logic [63:0] redirect_pc_i, inst_pc_o;
  logic [31:0] inst_o;

  instruction_fetch_if #(.ADDR_W(AW)) bus ();

  instruction_fetch #(
    .ADDR_W   (AW),
    .RESET_PC (RPC),
    .DEPTH    (DEP),
    .TIMEOUT  (TMO)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .bus           (bus),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i),
    .fetch_fault_o (fetch_fault_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: bus request status plus a queue of fetched words.
  bit          m_stb, m_drop, m_fault;
  logic [63:0] m_adr, m_tgt;
  int          m_tmo;
  logic [95:0] mq[$];

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_stb = 0; m_drop = 0; m_fault = 0; m_tmo = 0;
    m_adr = RPC; m_tgt = RPC;
    mq.delete();
  endtask

  task automatic compare_outputs();
    check("istb", 96'(bus.istb_o), 96'(m_stb));
    check("iadr", 96'(bus.iadr_o), 96'(m_adr));
    check("valid", 96'(inst_valid_o), 96'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("inst", 96'(inst_o), 96'(mq[0][95:64]));
      check("inst_pc", 96'(inst_pc_o), 96'(mq[0][63:0]));
    end
    check("fault", 96'(fetch_fault_o), 96'(m_fault));
  endtask

  task automatic step(input bit rst, input bit rd, input logic [63:0] rpc,
                      input bit ack, input bit rdy);
    logic [31:0] dat;
    logic [63:0] npc;
    bit          ackd, popd;
    dat = $urandom;
    reset_i       = rst;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    bus.iack_i    = ack;
    bus.idat_i    = dat;
    inst_ready_i  = rdy;
    ackd = m_stb && ack;
    popd = (mq.size() > 0) && rdy && !rd;
    npc  = {rpc[63:2], 2'b00};
    if (!rst) begin
      model_reset();
    end else if (rd) begin
      mq.delete();
      m_fault = 0;
      if (!m_stb) begin
        m_stb = 1; m_adr = npc; m_drop = 0; m_tmo = 0;
      end else if (ackd) begin
        m_adr = npc; m_drop = 0; m_tmo = 0;
      end else begin
        m_tgt = npc;
        if (m_drop) m_tmo = (m_tmo == TMO - 1) ? m_tmo : m_tmo + 1;
        else        m_tmo = 0;
        m_drop = 1;
      end
    end else begin
      if (popd) void'(mq.pop_front());
      if (ackd) begin
        if (m_drop) begin
          m_drop = 0;
          m_adr  = m_tgt;
        end else begin
          mq.push_back({dat, m_adr});
          m_adr = m_adr + 64'd4;
          m_stb = (mq.size() < DEP);
        end
        m_tmo = 0;
      end else if (m_stb) begin
`ifdef IFETCH_TIMEOUT_EN
        if (m_tmo == TMO - 1) begin
          m_stb = 0; m_fault = 1;
        end else begin
          m_tmo++;
        end
`endif
      end else if (!m_fault && mq.size() < DEP) begin
        m_stb = 1; m_tmo = 0;
      end
    end
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  initial begin
    reset_i = 0; redirect_i = 0; redirect_pc_i = '0; inst_ready_i = 0;
    bus.iack_i = 0; bus.idat_i = '0;
    model_reset();

    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    check("rst_inst", 96'(inst_o), 96'h0);
    check("rst_inst_pc", 96'(inst_pc_o), 96'h0);

    // streaming after reset release
    step(1, 0, '0, 1, 1);
    check("t1_adr0", 96'(bus.iadr_o), 96'(64'hFFFF_FFFF_FFFF_FF00));
    step(1, 0, '0, 1, 1);
    check("t1_adr1", 96'(bus.iadr_o), 96'(64'hFFFF_FFFF_FFFF_FF04));
    check("t1_pc0", 96'(inst_pc_o), 96'(64'hFFFF_FFFF_FFFF_FF00));
    step(1, 0, '0, 1, 1);
    check("t1_adr2", 96'(bus.iadr_o), 96'(64'hFFFF_FFFF_FFFF_FF08));
    check("t1_pc1", 96'(inst_pc_o), 96'(64'hFFFF_FFFF_FFFF_FF04));

    // FIFO fills, strobe drops, pop re-arms
    step(1, 1, 64'h100, 1, 1);
    step(1, 0, '0, 1, 0);
    step(1, 0, '0, 1, 0);
    check("t2_stb_low", 96'(bus.istb_o), 96'h0);
    step(1, 0, '0, 1, 0);
    check("t2_hold", 96'(bus.istb_o), 96'h0);
    check("t2_head", 96'(inst_pc_o), 96'h100);
    step(1, 0, '0, 1, 1);
    check("t2_rearm", 96'(bus.istb_o), 96'h1);

    // redirect during wait states
    step(1, 1, 64'h500, 1, 1);
    step(1, 0, '0, 0, 1);
    step(1, 1, 64'h1000, 0, 1);
    check("t3_old_adr", 96'(bus.iadr_o), 96'h500);
    step(1, 0, '0, 0, 1);
    step(1, 0, '0, 1, 1);
    check("t3_new_adr", 96'(bus.iadr_o), 96'h1000);
    check("t3_no_valid", 96'(inst_valid_o), 96'h0);

    // redirect coincident with ack
    step(1, 1, 64'h2003, 1, 1);
    check("t4_adr", 96'(bus.iadr_o), 96'h2000);
    check("t4_empty", 96'(inst_valid_o), 96'h0);

    // address wrap
    step(1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 1);
    step(1, 0, '0, 1, 1);
    check("wrap_adr", 96'(bus.iadr_o), 96'h0);
    check("wrap_pc", 96'(inst_pc_o), 96'(64'hFFFF_FFFF_FFFF_FFFC));

`ifdef IFETCH_TIMEOUT_EN
    step(1, 1, 64'h300, 1, 1);
    repeat (TMO - 1) step(1, 0, '0, 0, 1);
    check("t5_still_stb", 96'(bus.istb_o), 96'h1);
    step(1, 0, '0, 0, 1);
    check("t5_stb_drop", 96'(bus.istb_o), 96'h0);
    check("t5_fault", 96'(fetch_fault_o), 96'h1);
    step(1, 1, 64'h40, 0, 1);
    check("t5_clear", 96'(fetch_fault_o), 96'h0);
    check("t5_adr", 96'(bus.iadr_o), 96'h40);
`endif

    // reset in the middle of a wait state
    step(1, 1, 64'h600, 1, 1);
    step(1, 0, '0, 0, 1);
    step(0, 0, '0, 1, 1);
    check("t6_stb", 96'(bus.istb_o), 96'h0);
    check("t6_adr", 96'(bus.iadr_o), 96'(RPC));
    check("t6_valid", 96'(inst_valid_o), 96'h0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 19) == 0,
           {$urandom, $urandom},
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 9) < 7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
